alu_mem_stage: RTL and testbench

Execute/memory/write-back slice of the single-cycle 32-bit datapath. It chooses the ALU B operand between register data and a sign-extended immediate, computes the ALU result and zero flag, and accesses a 64-word data memory addressed by the ALU result. It then selects the write-back value from memory data or the ALU result. The register file, sign extender and destination-register mux sit upstream and are not part of this block.

---
 rtl/alu_mem_stage.sv | 87 ++++++++
 tb/tb_alu_mem_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mem_stage.sv
// alu_mem_stage: execute / memory / write-back slice of the single-cycle
// 32-bit datapath. Picks the ALU B operand, computes the ALU result and the
// zero flag, accesses a 64-word data memory addressed by the ALU result, and
// selects the write-back value.
module alu_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ALUcontrol,
    input  logic        ALUSrc,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    input  logic [31:0] imm,
    output logic [31:0] ALU_result,
    output logic        is0,
    output logic [31:0] ReadDataMem,
    output logic [31:0] out_MemtoReg
);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_XOR  = 4'b0010,
        OP_NOR  = 4'b0011,
        OP_ADD  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_SLL  = 4'b1001,
        OP_SRL  = 4'b1010,
        OP_SRA  = 4'b1011
    } alu_op_e;

    logic [31:0] operand_b;
    logic [4:0]  shift_amount;
    logic [5:0]  mem_addr;
    logic [31:0] mem [0:63];

    // B operand: the immediate replaces the register operand when ALUSrc = 1.
    assign operand_b    = ALUSrc ? imm : ReadData2;
    assign shift_amount = operand_b[4:0];

    // ALU: undefined operation codes produce 0 so the zero flag reads 1.
    always_comb begin
        ALU_result = 32'h0;
        case (alu_op_e'(ALUcontrol))
            OP_AND:  ALU_result = ReadData1 & operand_b;
            OP_OR:   ALU_result = ReadData1 | operand_b;
            OP_XOR:  ALU_result = ReadData1 ^ operand_b;
            OP_NOR:  ALU_result = ~(ReadData1 | operand_b);
            OP_ADD:  ALU_result = ReadData1 + operand_b;
            OP_SUB:  ALU_result = ReadData1 - operand_b;
            OP_SLT:  ALU_result = {31'h0, $signed(ReadData1) < $signed(operand_b)};
            OP_SLTU: ALU_result = {31'h0, ReadData1 < operand_b};
            OP_SLL:  ALU_result = ReadData1 << shift_amount;
            OP_SRL:  ALU_result = ReadData1 >> shift_amount;
            OP_SRA:  ALU_result = 32'($signed(ReadData1) >>> shift_amount);
            default: ALU_result = 32'h0;
        endcase
    end

    assign is0 = (ALU_result == 32'h0);

    // Only the low six bits address the memory, so addresses wrap modulo 64.
    assign mem_addr = ALU_result[5:0];

    // Data memory: reset clears every word at once and blocks writes while
    // held; the store data is always ReadData2, never the muxed B operand.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (MemWrite) begin
            mem[mem_addr] <= ReadData2;
        end
    end

    // Read data is gated to zero unless MemRead is asserted.
    assign ReadDataMem = MemRead ? mem[mem_addr] : 32'h0;

    // Write-back select: 1 picks the ALU result, 0 picks memory data.
    assign out_MemtoReg = MemtoReg ? ALU_result : ReadDataMem;

endmodule

// File: tb/tb_alu_mem_stage.sv
// tb_alu_mem_stage: directed self-checking bench for alu_mem_stage.
module tb_alu_mem_stage;

    logic        clk;
    logic        reset;
    logic [3:0]  ALUcontrol;
    logic        ALUSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] imm;
    logic [31:0] ALU_result;
    logic        is0;
    logic [31:0] ReadDataMem;
    logic [31:0] out_MemtoReg;

    int checks = 0;
    int errors = 0;

    alu_mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .ALUcontrol   (ALUcontrol),
        .ALUSrc       (ALUSrc),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemtoReg     (MemtoReg),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .imm          (imm),
        .ALU_result   (ALU_result),
        .is0          (is0),
        .ReadDataMem  (ReadDataMem),
        .out_MemtoReg (out_MemtoReg)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Point the ALU at a memory address: address = ReadData1 + imm.
    task automatic set_addr(input logic [31:0] base, input logic [31:0] offset);
        ReadData1  = base;
        imm        = offset;
        ALUSrc     = 1'b1;
        ALUcontrol = 4'b0101;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        MemRead = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b0;
        ReadData2 = 32'h0;
        set_addr(32'h0, 32'h7);
        #2;
        checks++;
        if (ReadDataMem !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_read got %h expected %h", ReadDataMem, 32'h0);
        end
        checks++;
        if (out_MemtoReg !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_wb got %h expected %h", out_MemtoReg, 32'h0);
        end
        checks++;
        if (ALU_result !== 32'h7) begin
            errors++;
            $display("[TB] FAIL reset_alu got %h expected %h", ALU_result, 32'h7);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add_reg;
        @(negedge clk);
        ReadData1 = 32'd5; ReadData2 = 32'd7; ALUSrc = 1'b0;
        ALUcontrol = 4'b0101; MemtoReg = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        checks++;
        if (ALU_result !== 32'd12 || is0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_reg got %h/%b expected %h/0", ALU_result, is0, 32'd12);
        end
        checks++;
        if (out_MemtoReg !== 32'd12) begin
            errors++;
            $display("[TB] FAIL add_wb got %h expected %h", out_MemtoReg, 32'd12);
        end
        // Immediate must be ignored when ALUSrc = 0.
        imm = 32'd100;
        #1;
        checks++;
        if (ALU_result !== 32'd12) begin
            errors++;
            $display("[TB] FAIL add_src0 got %h expected %h", ALU_result, 32'd12);
        end
    endtask

    task automatic test_store_load;
        @(negedge clk);
        set_addr(32'd8, 32'd4);
        ReadData2 = 32'hDEADBEEF; MemWrite = 1'b1; MemRead = 1'b0; MemtoReg = 1'b0;
        #1;
        checks++;
        if (ALU_result !== 32'd12) begin
            errors++;
            $display("[TB] FAIL store_addr got %h expected %h", ALU_result, 32'd12);
        end
        @(negedge clk);
        MemWrite = 1'b0; MemRead = 1'b1; ReadData2 = 32'h0;
        #1;
        checks++;
        if (out_MemtoReg !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL load_wb got %h expected %h", out_MemtoReg, 32'hDEADBEEF);
        end
    endtask

    task automatic test_logic_ops;
        logic [3:0]  ops [5]  = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
        logic [31:0] exp [5]  = '{32'h00F0000F, 32'hFFF00FFF, 32'hFF000FF0,
                                  32'h000FF000, 32'h0};
        @(negedge clk);
        ReadData1 = 32'hF0F000FF; ReadData2 = 32'h0FF00F0F; ALUSrc = 1'b0;
        MemtoReg = 1'b1; MemRead = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ALUcontrol = ops[i];
            #1;
            checks++;
            if (ALU_result !== exp[i] || is0 !== (exp[i] == 32'h0)) begin
                errors++;
                $display("[TB] FAIL logic_op%b got %h/%b expected %h", ops[i], ALU_result, is0, exp[i]);
            end
        end
    endtask

    task automatic test_sub_zero;
        @(negedge clk);
        ReadData1 = 32'h1234; ReadData2 = 32'h1234; ALUSrc = 1'b0; ALUcontrol = 4'b0110;
        #1;
        checks++;
        if (ALU_result !== 32'h0 || is0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_zero got %h/%b expected 0/1", ALU_result, is0);
        end
        ReadData2 = 32'h1235;
        #1;
        checks++;
        if (ALU_result !== 32'hFFFFFFFF || is0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_neg got %h/%b expected ffffffff/0", ALU_result, is0);
        end
    endtask

    task automatic test_compare_shift;
        @(negedge clk);
        ReadData1 = 32'hFFFFFFFF; ReadData2 = 32'd1; ALUSrc = 1'b0; ALUcontrol = 4'b0111;
        #1;
        checks++;
        if (ALU_result !== 32'd1) begin
            errors++;
            $display("[TB] FAIL slt got %h expected %h", ALU_result, 32'd1);
        end
        ALUcontrol = 4'b1000;
        #1;
        checks++;
        if (ALU_result !== 32'd0) begin
            errors++;
            $display("[TB] FAIL sltu got %h expected %h", ALU_result, 32'd0);
        end
        ReadData1 = 32'h80000000; imm = 32'd4; ALUSrc = 1'b1; ALUcontrol = 4'b1011;
        #1;
        checks++;
        if (ALU_result !== 32'hF8000000) begin
            errors++;
            $display("[TB] FAIL sra got %h expected %h", ALU_result, 32'hF8000000);
        end
        ALUcontrol = 4'b1010;
        #1;
        checks++;
        if (ALU_result !== 32'h08000000) begin
            errors++;
            $display("[TB] FAIL srl got %h expected %h", ALU_result, 32'h08000000);
        end
        // Shift amount uses only B[4:0]: 0x21 shifts by 1.
        ReadData1 = 32'h1; imm = 32'h21; ALUcontrol = 4'b1001;
        #1;
        checks++;
        if (ALU_result !== 32'h2) begin
            errors++;
            $display("[TB] FAIL sll got %h expected %h", ALU_result, 32'h2);
        end
    endtask

    task automatic test_wrap_gating;
        @(negedge clk);
        set_addr(32'h40, 32'h3);
        ReadData2 = 32'hA5; MemWrite = 1'b1; MemRead = 1'b0; MemtoReg = 1'b0;
        @(negedge clk);
        MemWrite = 1'b0; MemRead = 1'b1;
        set_addr(32'h3, 32'h0);
        #1;
        checks++;
        if (ReadDataMem !== 32'hA5) begin
            errors++;
            $display("[TB] FAIL wrap_read got %h expected %h", ReadDataMem, 32'hA5);
        end
        MemRead = 1'b0;
        #1;
        checks++;
        if (ReadDataMem !== 32'h0 || out_MemtoReg !== 32'h0) begin
            errors++;
            $display("[TB] FAIL read_gate got %h/%h expected 0/0", ReadDataMem, out_MemtoReg);
        end
    endtask

    task automatic test_back_to_back;
        // Simultaneous read and write: old data before the edge, new after.
        @(negedge clk);
        set_addr(32'h3, 32'h0);
        ReadData2 = 32'h12345678; MemRead = 1'b1; MemWrite = 1'b1;
        #1;
        checks++;
        if (ReadDataMem !== 32'hA5) begin
            errors++;
            $display("[TB] FAIL rw_before got %h expected %h", ReadDataMem, 32'hA5);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ReadDataMem !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL rw_after got %h expected %h", ReadDataMem, 32'h12345678);
        end
        MemWrite = 1'b0;
    endtask

    task automatic test_reset_mem;
        @(negedge clk);
        set_addr(32'd10, 32'h0);
        ReadData2 = 32'h55; MemWrite = 1'b1; MemRead = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        #1;
        checks++;
        if (ReadDataMem !== 32'h55) begin
            errors++;
            $display("[TB] FAIL fill10 got %h expected %h", ReadDataMem, 32'h55);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (ReadDataMem !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_clear got %h expected %h", ReadDataMem, 32'h0);
        end
        // Write held across an edge while reset is high must not land.
        ReadData2 = 32'h77; MemWrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (ReadDataMem !== 32'h0) begin
            errors++;
            $display("[TB] FAIL write_in_reset got %h expected %h", ReadDataMem, 32'h0);
        end
        set_addr(32'd12, 32'h0);
        #1;
        checks++;
        if (ReadDataMem !== 32'h0) begin
            errors++;
            $display("[TB] FAIL clear_addr12 got %h expected %h", ReadDataMem, 32'h0);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        reset = 1'b1;
        ALUcontrol = 4'b0; ALUSrc = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        MemtoReg = 1'b0; ReadData1 = 32'h0; ReadData2 = 32'h0; imm = 32'h0;
        test_reset;
        test_add_reg;
        test_store_load;
        test_logic_ops;
        test_sub_zero;
        test_compare_shift;
        test_wrap_gating;
        test_back_to_back;
        test_reset_mem;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
